// File: rtl/encoder_pkg.sv
// Step codes shared by the quadrature decoder and every consumer of its dir output,
// plus a decode helper so each consumer interprets the codes the same way.
package encoder_pkg;

  localparam logic [1:0] DIR_NONE    = 2'b00;
  localparam logic [1:0] DIR_CW      = 2'b10;
  localparam logic [1:0] DIR_CCW     = 2'b01;
  localparam logic [1:0] DIR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_BAD  = 2'd3
  } step_e;

  function automatic step_e decode_dir(input logic [1:0] d);
    step_e s;
    case (d)
      DIR_CW:      s = STEP_UP;
      DIR_CCW:     s = STEP_DOWN;
      DIR_ILLEGAL: s = STEP_BAD;
      default:     s = STEP_HOLD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/encoder_velocity_window.sv
// Fixed-length gate that counts net steps per window into a saturating accumulator
// and publishes the total, with a one-cycle valid pulse, when the window closes.
module encoder_velocity_window
  import encoder_pkg::*;
#(
  parameter int VEL_WINDOW = 1000,
  parameter int VEL_WIDTH  = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  step_e                       step_i,
  output logic signed [VEL_WIDTH-1:0] velocity_o,
  output logic                        vel_valid_o
);

  localparam int CNT_W = (VEL_WINDOW > 2) ? $clog2(VEL_WINDOW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEL_WINDOW - 1);
  localparam logic signed [VEL_WIDTH-1:0] VEL_MAX = {1'b0, {(VEL_WIDTH-1){1'b1}}};
  localparam logic signed [VEL_WIDTH-1:0] VEL_MIN = {1'b1, {(VEL_WIDTH-1){1'b0}}};

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [VEL_WIDTH-1:0] acc_q, acc_d;
  logic signed [VEL_WIDTH-1:0] vel_q, vel_d;
  logic                        valid_q, valid_d;
  logic signed [VEL_WIDTH-1:0] acc_step;
  logic                        terminal;

  assign terminal = (cnt_q == CNT_LAST);

  // Accumulator pins at its limits instead of wrapping; illegal codes add nothing.
  always_comb begin
    acc_step = acc_q;
    if (step_i == STEP_UP && acc_q != VEL_MAX) begin
      acc_step = acc_q + VEL_WIDTH'(1);
    end else if (step_i == STEP_DOWN && acc_q != VEL_MIN) begin
      acc_step = acc_q - VEL_WIDTH'(1);
    end
  end

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    acc_d   = acc_step;
    vel_d   = vel_q;
    valid_d = 1'b0;
    if (terminal) begin
      cnt_d   = '0;
      acc_d   = '0;
      vel_d   = acc_step;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      vel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      vel_q   <= vel_d;
      valid_q <= valid_d;
    end
  end

  assign velocity_o  = vel_q;
  assign vel_valid_o = valid_q;

endmodule

// File: rtl/encoder_position_counter.sv
// Signed absolute position tracker fed by the decoder's per-clock dir code, with
// sticky overflow / illegal-code flags and a windowed velocity measurement.
module encoder_position_counter
  import encoder_pkg::*;
#(
  parameter int POS_WIDTH  = 16,
  parameter int VEL_WINDOW = 1000,
  parameter int VEL_WIDTH  = 12,
  parameter int SATURATE   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  dir,
  input  logic                        zero,
  input  logic                        preset_en,
  input  logic signed [POS_WIDTH-1:0] preset_val,
  input  logic                        clr_flags,
  output logic signed [POS_WIDTH-1:0] position,
  output logic signed [VEL_WIDTH-1:0] velocity,
  output logic                        vel_valid,
  output logic                        overflow,
  output logic                        dir_err
);

  localparam logic signed [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic signed [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};
  localparam bit CLAMP = (SATURATE != 0);

  step_e                       step;
  logic signed [POS_WIDTH-1:0] pos_q, pos_d;
  logic                        ovf_q, ovf_d;
  logic                        err_q, err_d;
  logic                        ovf_set;
  logic                        err_set;

  assign step = decode_dir(dir);

  // zero beats preset beats step; a discarded step cannot raise overflow.
  always_comb begin
    pos_d   = pos_q;
    ovf_set = 1'b0;
    if (zero) begin
      pos_d = '0;
    end else if (preset_en) begin
      pos_d = preset_val;
    end else if (step == STEP_UP) begin
      if (pos_q == POS_MAX) begin
        ovf_set = 1'b1;
        pos_d   = CLAMP ? POS_MAX : POS_MIN;
      end else begin
        pos_d = pos_q + POS_WIDTH'(1);
      end
    end else if (step == STEP_DOWN) begin
      if (pos_q == POS_MIN) begin
        ovf_set = 1'b1;
        pos_d   = CLAMP ? POS_MIN : POS_MAX;
      end else begin
        pos_d = pos_q - POS_WIDTH'(1);
      end
    end
  end

  // An illegal code is reported even when zero/preset discard the step.
  always_comb begin
    err_set = (step == STEP_BAD);
    ovf_d   = ovf_set | (ovf_q & ~clr_flags);
    err_d   = err_set | (err_q & ~clr_flags);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  encoder_velocity_window #(
    .VEL_WINDOW (VEL_WINDOW),
    .VEL_WIDTH  (VEL_WIDTH)
  ) u_vel (
    .clk         (clk),
    .rst         (rst),
    .step_i      (step),
    .velocity_o  (velocity),
    .vel_valid_o (vel_valid)
  );

  assign position = pos_q;
  assign overflow = ovf_q;
  assign dir_err  = err_q;

endmodule

// File: tb/tb_encoder_position_counter.sv
// Directed bench driving a wrapping and a clamping instance with shared stimulus.
module tb_encoder_position_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dir;
  logic        zero;
  logic        preset_en;
  logic [15:0] preset_val;
  logic        clr_flags;

  logic [15:0] pos_w, pos_s;
  logic [11:0] vel_w, vel_s;
  logic        vv_w, vv_s;
  logic        ovf_w, ovf_s;
  logic        err_w, err_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  encoder_position_counter #(
    .POS_WIDTH(16), .VEL_WINDOW(10), .VEL_WIDTH(12), .SATURATE(0)
  ) dut_wrap (
    .clk(clk), .rst(rst), .dir(dir), .zero(zero), .preset_en(preset_en),
    .preset_val(preset_val), .clr_flags(clr_flags), .position(pos_w),
    .velocity(vel_w), .vel_valid(vv_w), .overflow(ovf_w), .dir_err(err_w)
  );

  encoder_position_counter #(
    .POS_WIDTH(16), .VEL_WINDOW(10), .VEL_WIDTH(12), .SATURATE(1)
  ) dut_sat (
    .clk(clk), .rst(rst), .dir(dir), .zero(zero), .preset_en(preset_en),
    .preset_val(preset_val), .clr_flags(clr_flags), .position(pos_s),
    .velocity(vel_s), .vel_valid(vv_s), .overflow(ovf_s), .dir_err(err_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick(input logic [1:0] d);
    dir = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pos_w"}, pos_w, 0);
    chk({tag, "_pos_s"}, pos_s, 0);
    chk({tag, "_vel"},   vel_w, 0);
    chk({tag, "_vv"},    vv_w, 0);
    chk({tag, "_ovf"},   ovf_w, 0);
    chk({tag, "_err"},   err_w, 0);
  endtask

  initial begin
    rst = 1'b1; dir = 2'b00; zero = 1'b0; preset_en = 1'b0;
    preset_val = 16'h0000; clr_flags = 1'b0;
    #1;
    chk_all_zero("reset_async");
    tick(2'b00);
    tick(2'b00);
    rst = 1'b0;

    // Counting, one-cycle latency
    tick(2'b10);
    chk("latency_pos", pos_w, 16'h0001);
    repeat (4) tick(2'b10);
    chk("cw5_pos", pos_w, 16'h0005);
    repeat (2) tick(2'b01);
    chk("cw5_ccw2_pos", pos_w, 16'h0003);

    // Illegal code and flag clearing
    tick(2'b11);
    chk("illegal_pos", pos_w, 16'h0003);
    chk("illegal_err", err_w, 1'b1);
    clr_flags = 1'b1;
    tick(2'b11);
    chk("clr_vs_set_err", err_w, 1'b1);
    tick(2'b00);
    chk("clr_alone_err", err_w, 1'b0);
    clr_flags = 1'b0;

    // Positive limit; preset discards the concurrent step
    preset_en = 1'b1; preset_val = 16'h7FFE;
    tick(2'b10);
    chk("preset_pos", pos_w, 16'h7FFE);
    preset_en = 1'b0;
    tick(2'b10);
    chk("to_max_w", pos_w, 16'h7FFF);
    chk("to_max_s", pos_s, 16'h7FFF);
    chk("to_max_ovf", ovf_w, 1'b0);
    tick(2'b10);
    chk("over_max_w", pos_w, 16'h8000);
    chk("over_max_s", pos_s, 16'h7FFF);
    chk("over_max_ovf_w", ovf_w, 1'b1);
    chk("over_max_ovf_s", ovf_s, 1'b1);
    tick(2'b10);
    chk("third_w", pos_w, 16'h8001);
    chk("third_s", pos_s, 16'h7FFF);
    tick(2'b01);
    chk("away_w", pos_w, 16'h8000);
    chk("away_s", pos_s, 16'h7FFE);
    zero = 1'b1;
    tick(2'b00);
    zero = 1'b0;
    chk("zero_pos", pos_s, 16'h0000);
    chk("zero_keeps_ovf", ovf_s, 1'b1);
    clr_flags = 1'b1;
    tick(2'b00);
    clr_flags = 1'b0;
    chk("clr_ovf_w", ovf_w, 1'b0);
    chk("clr_ovf_s", ovf_s, 1'b0);

    // Negative limit
    preset_en = 1'b1; preset_val = 16'h8000;
    tick(2'b00);
    preset_en = 1'b0;
    tick(2'b01);
    chk("under_min_w", pos_w, 16'h7FFF);
    chk("under_min_s", pos_s, 16'h8000);
    chk("under_min_ovf", ovf_w, 1'b1);

    // Asynchronous reset in the middle of activity
    tick(2'b11);
    tick(2'b10);
    tick(2'b10);
    #3 rst = 1'b1;
    #1;
    chk_all_zero("reset_mid");
    dir = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;

    // Window 1 (cycles 1..10): +4 -1, zero on cycle 4, illegal on cycle 6
    tick(2'b10); tick(2'b10); tick(2'b10);
    zero = 1'b1;
    tick(2'b10);
    zero = 1'b0;
    chk("zero_with_step_pos", pos_w, 16'h0000);
    tick(2'b01);
    chk("neg_pos_w", pos_w, 16'hFFFF);
    chk("neg_pos_s", pos_s, 16'hFFFF);
    tick(2'b11);
    tick(2'b00); tick(2'b00); tick(2'b00);
    chk("win1_pre_vv", vv_w, 1'b0);
    tick(2'b00);
    chk("win1_vv", vv_w, 1'b1);
    chk("win1_vel", vel_w, 12'h003);
    chk("win1_vel_s", vel_s, 12'h003);
    tick(2'b00);
    chk("win1_vv_drop", vv_w, 1'b0);
    chk("win1_vel_hold", vel_w, 12'h003);

    // Window 2 (cycles 11..20): empty
    repeat (8) tick(2'b00);
    chk("win2_pre_vv", vv_w, 1'b0);
    tick(2'b00);
    chk("win2_vv", vv_w, 1'b1);
    chk("win2_vel", vel_w, 12'h000);

    // Window 3 (cycles 21..30): -3, last step on the terminal cycle
    tick(2'b01); tick(2'b01);
    repeat (7) tick(2'b00);
    tick(2'b01);
    chk("win3_vv", vv_w, 1'b1);
    chk("win3_vel", vel_w, 12'hFFD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
